// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: PS/2 make/break parser plus age-ranked slot pool.
// Optional build macro VOICE_STEAL_EN: a press with all slots busy steals the oldest slot.
module voice_allocator #(
    parameter int         NUM_VOICES  = 4,
    parameter logic [5:0] SILENT_CODE = 6'd48
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scan_valid,
    input  logic [7:0]                scan_code,
    input  logic [5:0]                note_code,
    input  logic                      all_off,
    output logic [6*NUM_VOICES-1:0]   voice_code,
    output logic [NUM_VOICES-1:0]     voice_active,
    output logic                      note_on,
    output logic                      note_off,
    output logic [2:0]                event_slot,
    output logic                      overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK
    } state_e;

    state_e                fsm_q, fsm_d;
    logic [5:0]            code_q [NUM_VOICES];
    logic [5:0]            code_d [NUM_VOICES];
    logic [2:0]            rank_q [NUM_VOICES];
    logic [2:0]            rank_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] act_q, act_d;
    logic                  on_q, on_d;
    logic                  off_q, off_d;
    logic                  ovf_q, ovf_d;
    logic [2:0]            slot_q, slot_d;

    logic       make_ev, brk_ev;
    logic       hit, free;
    logic [2:0] hit_idx, free_idx, vic_idx, hit_rank;

    // Parser: only plain make codes and plain break codes become events
    always_comb begin
        fsm_d   = fsm_q;
        make_ev = 1'b0;
        brk_ev  = 1'b0;
        if (scan_valid) begin
            unique case (fsm_q)
                S_IDLE: begin
                    if (scan_code == 8'hF0)      fsm_d = S_BRK;
                    else if (scan_code == 8'hE0) fsm_d = S_EXT;
                    else                         make_ev = 1'b1;
                end
                S_BRK: begin
                    brk_ev = 1'b1;
                    fsm_d  = S_IDLE;
                end
                S_EXT:     fsm_d = (scan_code == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_EXT_BRK: fsm_d = S_IDLE;
            endcase
        end
    end

    // Descending scan so the lowest-index free slot wins
    always_comb begin
        hit      = 1'b0;
        free     = 1'b0;
        hit_idx  = 3'd0;
        free_idx = 3'd0;
        vic_idx  = 3'd0;
        hit_rank = 3'd0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (act_q[i] && code_q[i] == note_code) begin
                hit      = 1'b1;
                hit_idx  = 3'(i);
                hit_rank = rank_q[i];
            end
            if (!act_q[i]) begin
                free     = 1'b1;
                free_idx = 3'(i);
            end
            if (act_q[i] && rank_q[i] == 3'(NUM_VOICES - 1))
                vic_idx = 3'(i);
        end
    end

    always_comb begin
        code_d = code_q;
        rank_d = rank_q;
        act_d  = act_q;
        on_d   = 1'b0;
        off_d  = 1'b0;
        ovf_d  = 1'b0;
        slot_d = slot_q;
        if (all_off) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                code_d[i] = SILENT_CODE;
                rank_d[i] = 3'd0;
            end
            act_d = '0;
        end else if (make_ev && note_code != SILENT_CODE && !hit) begin
            if (free) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (3'(i) == free_idx) begin
                        code_d[i] = note_code;
                        act_d[i]  = 1'b1;
                        rank_d[i] = 3'd0;
                    end else if (act_q[i]) begin
                        rank_d[i] = rank_q[i] + 3'd1;
                    end
                end
                on_d   = 1'b1;
                slot_d = free_idx;
            end else begin
`ifdef VOICE_STEAL_EN
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (3'(i) == vic_idx) begin
                        code_d[i] = note_code;
                        rank_d[i] = 3'd0;
                    end else begin
                        rank_d[i] = rank_q[i] + 3'd1;
                    end
                end
                on_d   = 1'b1;
                slot_d = vic_idx;
`endif
                ovf_d = 1'b1;
            end
        end else if (brk_ev && hit) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (3'(i) == hit_idx) begin
                    code_d[i] = SILENT_CODE;
                    act_d[i]  = 1'b0;
                    rank_d[i] = 3'd0;
                end else if (act_q[i] && rank_q[i] > hit_rank) begin
                    rank_d[i] = rank_q[i] - 3'd1;
                end
            end
            off_d  = 1'b1;
            slot_d = hit_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q  <= S_IDLE;
            act_q  <= '0;
            on_q   <= 1'b0;
            off_q  <= 1'b0;
            ovf_q  <= 1'b0;
            slot_q <= 3'd0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                code_q[i] <= SILENT_CODE;
                rank_q[i] <= 3'd0;
            end
        end else begin
            fsm_q  <= fsm_d;
            act_q  <= act_d;
            on_q   <= on_d;
            off_q  <= off_d;
            ovf_q  <= ovf_d;
            slot_q <= slot_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                code_q[i] <= code_d[i];
                rank_q[i] <= rank_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++)
            voice_code[6*i +: 6] = code_q[i];
    end

    assign voice_active = act_q;
    assign note_on      = on_q;
    assign note_off     = off_q;
    assign overflow     = ovf_q;
    assign event_slot   = slot_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed scoreboard bench for voice_allocator (4 voices).
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_valid;
    logic [7:0]  scan_code;
    logic [5:0]  note_code;
    logic        all_off;
    logic [23:0] voice_code;
    logic [3:0]  voice_active;
    logic        note_on;
    logic        note_off;
    logic [2:0]  event_slot;
    logic        overflow;

    always #5 clk = ~clk;

    voice_allocator #(
        .NUM_VOICES (4),
        .SILENT_CODE(6'd48)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_valid  (scan_valid),
        .scan_code   (scan_code),
        .note_code   (note_code),
        .all_off     (all_off),
        .voice_code  (voice_code),
        .voice_active(voice_active),
        .note_on     (note_on),
        .note_off    (note_off),
        .event_slot  (event_slot),
        .overflow    (overflow)
    );

    typedef struct {
        logic [23:0] code;
        logic [3:0]  act;
        logic        on;
        logic        off;
        logic [2:0]  slot;
        logic        ovf;
    } exp_t;

    exp_t       sbq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [5:0] ec[4];
    logic [2:0] es;

    task automatic push(input logic on, input logic off, input logic ovf);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.code[6*i +: 6] = ec[i];
            e.act[i]         = (ec[i] != 6'd48);
        end
        e.on   = on;
        e.off  = off;
        e.slot = es;
        e.ovf  = ovf;
        sbq.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] b, input logic [5:0] n,
                       input logic ao, input logic r);
        exp_t e;
        scan_valid = v;
        scan_code  = b;
        note_code  = n;
        all_off    = ao;
        reset      = r;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
        all_off    = 1'b0;
        reset      = 1'b0;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
        end else begin
            e = sbq.pop_front();
            cmp("voice_code", voice_code, e.code);
            cmp("voice_active", 24'(voice_active), 24'(e.act));
            cmp("note_on", 24'(note_on), 24'(e.on));
            cmp("note_off", 24'(note_off), 24'(e.off));
            cmp("event_slot", 24'(event_slot), 24'(e.slot));
            cmp("overflow", 24'(overflow), 24'(e.ovf));
        end
    endtask

    // expect no change and no pulses
    task automatic quiet(input logic v, input logic [7:0] b, input logic [5:0] n);
        push(1'b0, 1'b0, 1'b0);
        cyc(v, b, n, 1'b0, 1'b0);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 4; i++) ec[i] = 6'd48;
    endtask

    initial begin
        clear_exp();
        es = 3'd0;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        note_code  = 6'd48;
        all_off    = 1'b0;
        reset      = 1'b1;

        // reset state
        push(0, 0, 0); cyc(0, 8'h00, 6'd48, 0, 1);
        push(0, 0, 0); cyc(0, 8'h00, 6'd48, 0, 1);
        quiet(0, 8'h00, 6'd48);

        // two presses into slots 0 and 1
        ec[0] = 6'd25; es = 3'd0; push(1, 0, 0); cyc(1, 8'h1C, 6'd25, 0, 0);
        ec[1] = 6'd26; es = 3'd1; push(1, 0, 0); cyc(1, 8'h1B, 6'd26, 0, 0);
        quiet(0, 8'h00, 6'd48);

        // typematic repeat is ignored
        for (int k = 0; k < 3; k++) quiet(1, 8'h1C, 6'd25);

        // release 1C then 1B
        quiet(1, 8'hF0, 6'd48);
        ec[0] = 6'd48; es = 3'd0; push(0, 1, 0); cyc(1, 8'h1C, 6'd25, 0, 0);
        quiet(1, 8'hF0, 6'd48);
        ec[1] = 6'd48; es = 3'd1; push(0, 1, 0); cyc(1, 8'h1B, 6'd26, 0, 0);
        quiet(0, 8'h00, 6'd48);

        // extended sequences produce nothing
        quiet(1, 8'hE0, 6'd48);
        quiet(1, 8'h1C, 6'd25);
        quiet(1, 8'hE0, 6'd48);
        quiet(1, 8'hF0, 6'd48);
        quiet(1, 8'h1C, 6'd25);
        ec[0] = 6'd25; es = 3'd0; push(1, 0, 0); cyc(1, 8'h1C, 6'd25, 0, 0);
        quiet(1, 8'hF0, 6'd48);
        ec[0] = 6'd48; push(0, 1, 0); cyc(1, 8'h1C, 6'd25, 0, 0);

        // fill all four slots, then overflow twice
        ec[0] = 6'd0; es = 3'd0; push(1, 0, 0); cyc(1, 8'h15, 6'd0, 0, 0);
        ec[1] = 6'd1; es = 3'd1; push(1, 0, 0); cyc(1, 8'h1D, 6'd1, 0, 0);
        ec[2] = 6'd2; es = 3'd2; push(1, 0, 0); cyc(1, 8'h24, 6'd2, 0, 0);
        ec[3] = 6'd3; es = 3'd3; push(1, 0, 0); cyc(1, 8'h2D, 6'd3, 0, 0);
`ifdef VOICE_STEAL_EN
        ec[0] = 6'd4; es = 3'd0; push(1, 0, 1); cyc(1, 8'h2C, 6'd4, 0, 0);
        ec[1] = 6'd5; es = 3'd1; push(1, 0, 1); cyc(1, 8'h35, 6'd5, 0, 0);
`else
        push(0, 0, 1); cyc(1, 8'h2C, 6'd4, 0, 0);
        push(0, 0, 1); cyc(1, 8'h35, 6'd5, 0, 0);
`endif
        quiet(0, 8'h00, 6'd48);

        // all_off level without a byte
        clear_exp(); push(0, 0, 0); cyc(0, 8'h00, 6'd48, 1, 0);

        // rank bookkeeping across a release
        ec[0] = 6'd10; es = 3'd0; push(1, 0, 0); cyc(1, 8'h1C, 6'd10, 0, 0);
        ec[1] = 6'd11; es = 3'd1; push(1, 0, 0); cyc(1, 8'h1B, 6'd11, 0, 0);
        ec[2] = 6'd12; es = 3'd2; push(1, 0, 0); cyc(1, 8'h23, 6'd12, 0, 0);
        quiet(1, 8'hF0, 6'd48);
        ec[1] = 6'd48; es = 3'd1; push(0, 1, 0); cyc(1, 8'h1B, 6'd11, 0, 0);
        ec[1] = 6'd13; es = 3'd1; push(1, 0, 0); cyc(1, 8'h2B, 6'd13, 0, 0);
        ec[3] = 6'd14; es = 3'd3; push(1, 0, 0); cyc(1, 8'h34, 6'd14, 0, 0);
`ifdef VOICE_STEAL_EN
        ec[0] = 6'd15; es = 3'd0; push(1, 0, 1); cyc(1, 8'h33, 6'd15, 0, 0);
        ec[2] = 6'd16; es = 3'd2; push(1, 0, 1); cyc(1, 8'h3B, 6'd16, 0, 0);
`else
        push(0, 0, 1); cyc(1, 8'h33, 6'd15, 0, 0);
        push(0, 0, 1); cyc(1, 8'h3B, 6'd16, 0, 0);
`endif
        quiet(1, 8'hF0, 6'd48);
        ec[1] = 6'd48; es = 3'd1; push(0, 1, 0); cyc(1, 8'h2B, 6'd13, 0, 0);

        // all_off wins over a same-cycle make byte
        clear_exp(); push(0, 0, 0); cyc(1, 8'h1B, 6'd26, 1, 0);
        quiet(0, 8'h00, 6'd48);
        ec[0] = 6'd26; es = 3'd0; push(1, 0, 0); cyc(1, 8'h1B, 6'd26, 0, 0);

        // reset after F0: next byte is a make
        quiet(1, 8'hF0, 6'd48);
        clear_exp(); es = 3'd0; push(0, 0, 0); cyc(0, 8'h00, 6'd48, 0, 1);
        ec[0] = 6'd13; es = 3'd0; push(1, 0, 0); cyc(1, 8'h15, 6'd13, 0, 0);
        quiet(0, 8'h00, 6'd48);

        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL sb_leftover: observed %0d entries expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
